pcie_wbm_tgt_fanout: RTL

//  Downstream of the PCIe multi-function top: consumes its Wishbone master bus (ox_wbm_*) and its BAR/function decode.

---
 rtl/pcie_wbm_pkg.sv | 7 +
 rtl/pcie_wbm_watchdog.sv | 16 +
 rtl/pcie_wbm_tgt_fanout.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pcie_wbm_pkg.sv
// pcie_wbm_pkg: shared Wishbone widths, error data pattern and fan-out FSM states
package pcie_wbm_pkg;
    localparam int WB_DAT_W = 32;
    localparam int WB_ADR_W = 16;
    localparam logic [WB_DAT_W-1:0] WB_ERR_DATA = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {ST_IDLE, ST_SEL, ST_ACTIVE, ST_ABORT} wbm_state_e;
endpackage

// File: rtl/pcie_wbm_watchdog.sv
// pcie_wbm_watchdog: counts stalled strobe cycles and flags the cycle that reaches TO_CYCLES-1
module pcie_wbm_watchdog #(
    parameter int TO_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TO_CYCLES);
    logic [CW-1:0] cnt;
    assign expired = en & (cnt == CW'(TO_CYCLES - 1));
    always_ff @(posedge clk)
        cnt <= (rst | clr | expired) ? '0 : en ? cnt + CW'(1) : cnt;
endmodule

// File: rtl/pcie_wbm_tgt_fanout.sv
// pcie_wbm_tgt_fanout: fans the upstream Wishbone master out to NUM_TGT targets and
// guarantees every beat completes, substituting all-ones data on error, unmapped or timeout
module pcie_wbm_tgt_fanout
    import pcie_wbm_pkg::*;
#(
    parameter int                   NUM_TGT      = 4,
    parameter logic [3*NUM_TGT-1:0] TGT_FUNC_MAP = {3'd3, 3'd2, 3'd1, 3'd0},
    parameter logic [3*NUM_TGT-1:0] TGT_BAR_MAP  = {3'd0, 3'd0, 3'd0, 3'd0},
    parameter int                   TO_CYCLES    = 1024
) (
    input  logic                          ix_clk_125,
    input  logic                          ix_rst,
    input  logic [7:0]                    ix_wbm_cyc,
    input  logic                          ix_wbm_stb,
    input  logic                          ix_wbm_we,
    input  logic [WB_ADR_W-1:0]           ix_wbm_adr,
    input  logic [WB_DAT_W-1:0]           ix_wbm_dat,
    input  logic [3:0]                    ix_wbm_sel,
    input  logic [2:0]                    ix_wbm_cti,
    input  logic [1:0]                    ix_wbm_bte,
    input  logic [7:0]                    ix_dec_func_hit,
    input  logic [5:0]                    ix_dec_bar_hit,
    output logic                          ox_wbm_ack,
    output logic [WB_DAT_W-1:0]           ox_wbm_dat,
    output logic [NUM_TGT-1:0]            ox_tgt_cyc,
    output logic                          ox_tgt_stb,
    output logic                          ox_tgt_we,
    output logic [WB_ADR_W-1:0]           ox_tgt_adr,
    output logic [WB_DAT_W-1:0]           ox_tgt_dat,
    output logic [3:0]                    ox_tgt_sel,
    output logic [2:0]                    ox_tgt_cti,
    output logic [1:0]                    ox_tgt_bte,
    input  logic [NUM_TGT-1:0]            ix_tgt_ack,
    input  logic [NUM_TGT-1:0]            ix_tgt_err,
    input  logic [WB_DAT_W*NUM_TGT-1:0]   ix_tgt_dat,
    output logic                          ox_to_evt,
    output logic                          ox_unmap_evt,
    output logic [15:0]                   ox_err_cnt
);
    localparam int IW = NUM_TGT > 1 ? $clog2(NUM_TGT) : 1;

    wbm_state_e          state;
    logic [IW-1:0]       tgt_idx, hit_idx, nxt_idx;
    logic                hit_ok, nxt_ok;
    logic                cyc_any, live, active, sel_ack, sel_err, to_hit, unmap_now;
    logic [WB_DAT_W-1:0] sel_dat;

    assign cyc_any   = |ix_wbm_cyc;
    // reset gates the combinational paths so nothing is acked in the reset cycle
    assign live      = cyc_any & ~ix_rst;
    assign active    = live & (state == ST_ACTIVE);
    assign unmap_now = live & (state == ST_SEL) & ~hit_ok;

    always_comb begin
        nxt_ok     = 1'b0;
        nxt_idx    = '0;
        sel_ack    = 1'b0;
        sel_err    = 1'b0;
        sel_dat    = '0;
        ox_tgt_cyc = '0;
        for (int t = NUM_TGT - 1; t >= 0; t--)
            if (ix_dec_func_hit[TGT_FUNC_MAP[3*t+:3]] && ix_dec_bar_hit[TGT_BAR_MAP[3*t+:3]]) begin
                nxt_ok  = 1'b1;
                nxt_idx = IW'(t);
            end
        for (int t = 0; t < NUM_TGT; t++)
            if (tgt_idx == IW'(t)) begin
                sel_ack       = ix_tgt_ack[t];
                sel_err       = ix_tgt_err[t];
                sel_dat       = ix_tgt_dat[WB_DAT_W*t+:WB_DAT_W];
                ox_tgt_cyc[t] = active;
            end
    end

    pcie_wbm_watchdog #(.TO_CYCLES(TO_CYCLES)) u_wd (
        .clk     (ix_clk_125),
        .rst     (ix_rst),
        .clr     (~active | sel_ack | sel_err),
        .en      (active & ix_wbm_stb & ~sel_ack & ~sel_err),
        .expired (to_hit)
    );

    assign ox_wbm_ack = active ? (sel_ack | sel_err | to_hit)
                               : (live & ix_wbm_stb & (state == ST_ABORT));
    assign ox_wbm_dat = !ox_wbm_ack ? '0 : (active & sel_ack & ~sel_err) ? sel_dat : WB_ERR_DATA;
    assign ox_tgt_stb = ix_wbm_stb & active;
    assign ox_tgt_we  = ix_wbm_we;
    assign ox_tgt_adr = ix_wbm_adr;
    assign ox_tgt_dat = ix_wbm_dat;
    assign ox_tgt_sel = ix_wbm_sel;
    assign ox_tgt_cti = ix_wbm_cti;
    assign ox_tgt_bte = ix_wbm_bte;

    always_ff @(posedge ix_clk_125) begin
        if (ix_rst) begin
            state        <= ST_IDLE;
            hit_ok       <= 1'b0;
            hit_idx      <= '0;
            tgt_idx      <= '0;
            ox_to_evt    <= 1'b0;
            ox_unmap_evt <= 1'b0;
            ox_err_cnt   <= '0;
        end else begin
            ox_to_evt    <= to_hit;
            ox_unmap_evt <= unmap_now;
            ox_err_cnt   <= ((to_hit | unmap_now | (active & sel_err)) && ox_err_cnt != '1)
                            ? ox_err_cnt + 16'd1 : ox_err_cnt;
            if (!cyc_any)
                state <= ST_IDLE;
            else
                case (state)
                    ST_IDLE: if (ix_wbm_stb) begin
                        hit_ok  <= nxt_ok;
                        hit_idx <= nxt_idx;
                        state   <= ST_SEL;
                    end
                    ST_SEL: begin
                        tgt_idx <= hit_idx;
                        state   <= hit_ok ? ST_ACTIVE : ST_ABORT;
                    end
                    ST_ACTIVE: if (to_hit) state <= ST_ABORT;
                    default: ;
                endcase
        end
    end
endmodule
